// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared encodings for the MEM-stage load/store initiator: access sizes,
// FSM states, memory control levels and default limits.
package unidade_acesso_pkg;

   localparam int unsigned MEM_LIMITE_PADRAO = 1500;
   localparam int unsigned ACK_MAX_PADRAO    = 255;

   // The memory writes whenever controle is low, so read is the safe idle level.
   localparam logic CTRL_LEITURA = 1'b1;
   localparam logic CTRL_ESCRITA = 1'b0;

   typedef enum logic [1:0] {
      TAM_BYTE    = 2'b00,
      TAM_MEIA    = 2'b01,
      TAM_PALAVRA = 2'b10,
      TAM_ILEGAL  = 2'b11
   } tamanho_e;

   typedef enum logic [2:0] {
      OCIOSO,
      LEITURA,
      RMW_LEITURA,
      RMW_ESCRITA,
      ESCRITA,
      FIM
   } estado_e;

   function automatic logic desalinhado(input tamanho_e tam, input logic [1:0] desloc);
      return (tam == TAM_ILEGAL)
          || ((tam == TAM_MEIA) && desloc[0])
          || ((tam == TAM_PALAVRA) && (desloc != 2'b00));
   endfunction

endpackage

// File: rtl/unidade_acesso_memoria_if.sv
// Word-indexed data-memory bus: request/ack handshake with address, write data,
// read/write control and read data.
interface unidade_acesso_memoria_if;
   logic        mem_req;
   logic [31:0] mem_endereco;
   logic [31:0] mem_valor;
   logic        mem_controle;
   logic        mem_ack;
   logic [31:0] mem_saida;

   modport master (
      output mem_req, mem_endereco, mem_valor, mem_controle,
      input  mem_ack, mem_saida
   );

   modport slave (
      input  mem_req, mem_endereco, mem_valor, mem_controle,
      output mem_ack, mem_saida
   );
endinterface

// File: rtl/unidade_acesso_memoria_ajuste_subpalavra.sv
// Little-endian lane handling: extracts and extends a loaded byte/half, and
// merges store data into a word read back for read-modify-write.
module ajuste_subpalavra
   import unidade_acesso_pkg::*;
(
   input  logic [31:0] palavra_i,
   input  logic [31:0] dado_i,
   input  tamanho_e    tamanho_i,
   input  logic        sinal_i,
   input  logic [1:0]  desloc_i,
   output logic [31:0] carga_o,
   output logic [31:0] mescla_o
);

   logic [7:0]  byte_sel;
   logic [15:0] meia_sel;

   always_comb begin
      byte_sel = palavra_i[{desloc_i, 3'b000} +: 8];
      meia_sel = palavra_i[{desloc_i[1], 4'b0000} +: 16];

      carga_o = palavra_i;
      case (tamanho_i)
         TAM_BYTE: carga_o = {{24{sinal_i & byte_sel[7]}}, byte_sel};
         TAM_MEIA: carga_o = {{16{sinal_i & meia_sel[15]}}, meia_sel};
         default:  carga_o = palavra_i;
      endcase

      mescla_o = palavra_i;
      case (tamanho_i)
         TAM_BYTE:    mescla_o[{desloc_i, 3'b000} +: 8]     = dado_i[7:0];
         TAM_MEIA:    mescla_o[{desloc_i[1], 4'b0000} +: 16] = dado_i[15:0];
         TAM_PALAVRA: mescla_o = dado_i;
         default:     mescla_o = palavra_i;
      endcase
   end

endmodule

// File: rtl/unidade_acesso_memoria.sv
// MEM-stage load/store initiator: byte-addressed pipeline requests become
// word-indexed memory accesses; sub-word stores use read-modify-write.
//   state       | meaning
//   OCIOSO      | idle, checks and latches a new request
//   LEITURA     | load read in flight
//   RMW_LEITURA | read half of a sub-word store
//   RMW_ESCRITA | one idle gap cycle, then write of the merged word
//   ESCRITA     | full-word store in flight
//   FIM         | one-cycle response, pipeline released
module unidade_acesso_memoria
   import unidade_acesso_pkg::*;
#(
   parameter int unsigned MEM_LIMITE = MEM_LIMITE_PADRAO,
   parameter int unsigned ACK_MAX    = ACK_MAX_PADRAO
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            req_valido,
   input  logic                            req_escrita,
   input  logic [1:0]                      req_tamanho,
   input  logic                            req_sinal,
   input  logic [31:0]                     req_endereco,
   input  logic [31:0]                     req_dado,
   output logic                            stall,
   output logic                            resp_valido,
   output logic [31:0]                     resp_dado,
   output logic                            erro_alinhamento,
   output logic                            erro_limite,
   unidade_acesso_memoria_if.master        mem
);

   localparam int CW = $clog2(ACK_MAX + 1);
   localparam logic [CW-1:0] CNT_FIM = CW'(ACK_MAX - 1);

   estado_e       estado_q, estado_d;
   tamanho_e      tamanho_q, tamanho_d;
   logic          sinal_q, sinal_d;
   logic [1:0]    desloc_q, desloc_d;
   logic [31:0]   dado_q, dado_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_req_q, mem_req_d;
   logic [31:0]   mem_end_q, mem_end_d;
   logic [31:0]   mem_val_q, mem_val_d;
   logic          mem_ctl_q, mem_ctl_d;
   logic          resp_valido_q, resp_valido_d;
   logic [31:0]   resp_dado_q, resp_dado_d;
   logic          erro_alin_q, erro_alin_d;
   logic          erro_lim_q, erro_lim_d;

   tamanho_e      req_tam_e;
   logic          req_desal;
   logic          req_fora;
   logic [31:0]   carga;
   logic [31:0]   mescla;

   assign req_tam_e = tamanho_e'(req_tamanho);
   assign req_desal = desalinhado(req_tam_e, req_endereco[1:0]);
   assign req_fora  = {2'b00, req_endereco[31:2]} > MEM_LIMITE;

   ajuste_subpalavra u_ajuste (
      .palavra_i (mem.mem_saida),
      .dado_i    (dado_q),
      .tamanho_i (tamanho_q),
      .sinal_i   (sinal_q),
      .desloc_i  (desloc_q),
      .carga_o   (carga),
      .mescla_o  (mescla)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q      <= OCIOSO;
         tamanho_q     <= TAM_BYTE;
         sinal_q       <= 1'b0;
         desloc_q      <= 2'b00;
         dado_q        <= '0;
         cnt_q         <= '0;
         mem_req_q     <= 1'b0;
         mem_end_q     <= '0;
         mem_val_q     <= '0;
         mem_ctl_q     <= CTRL_LEITURA;
         resp_valido_q <= 1'b0;
         resp_dado_q   <= '0;
         erro_alin_q   <= 1'b0;
         erro_lim_q    <= 1'b0;
      end else begin
         estado_q      <= estado_d;
         tamanho_q     <= tamanho_d;
         sinal_q       <= sinal_d;
         desloc_q      <= desloc_d;
         dado_q        <= dado_d;
         cnt_q         <= cnt_d;
         mem_req_q     <= mem_req_d;
         mem_end_q     <= mem_end_d;
         mem_val_q     <= mem_val_d;
         mem_ctl_q     <= mem_ctl_d;
         resp_valido_q <= resp_valido_d;
         resp_dado_q   <= resp_dado_d;
         erro_alin_q   <= erro_alin_d;
         erro_lim_q    <= erro_lim_d;
      end
   end

   always_comb begin
      estado_d    = estado_q;
      tamanho_d   = tamanho_q;
      sinal_d     = sinal_q;
      desloc_d    = desloc_q;
      dado_d      = dado_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_end_d   = mem_end_q;
      mem_val_d   = mem_val_q;
      mem_ctl_d   = mem_ctl_q;
      resp_dado_d = resp_dado_q;
      erro_alin_d = erro_alin_q;
      erro_lim_d  = erro_lim_q;

      case (estado_q)
         OCIOSO: begin
            if (req_valido) begin
               tamanho_d   = req_tam_e;
               sinal_d     = req_sinal;
               desloc_d    = req_endereco[1:0];
               dado_d      = req_dado;
               cnt_d       = '0;
               resp_dado_d = '0;
               erro_alin_d = req_desal;
               erro_lim_d  = req_fora;
               if (req_desal || req_fora) begin
                  estado_d = FIM;
               end else begin
                  mem_req_d = 1'b1;
                  mem_end_d = {2'b00, req_endereco[31:2]};
                  if (!req_escrita) begin
                     estado_d  = LEITURA;
                     mem_ctl_d = CTRL_LEITURA;
                  end else if (req_tam_e == TAM_PALAVRA) begin
                     estado_d  = ESCRITA;
                     mem_ctl_d = CTRL_ESCRITA;
                     mem_val_d = req_dado;
                  end else begin
                     estado_d  = RMW_LEITURA;
                     mem_ctl_d = CTRL_LEITURA;
                  end
               end
            end
         end
         LEITURA, RMW_LEITURA, RMW_ESCRITA, ESCRITA: begin
            // Only the RMW gap cycle reaches here with the request low.
            if (!mem_req_q) begin
               mem_req_d = 1'b1;
               mem_ctl_d = CTRL_ESCRITA;
               cnt_d     = '0;
            end else if (mem.mem_ack) begin
               mem_req_d = 1'b0;
               mem_ctl_d = CTRL_LEITURA;
               cnt_d     = '0;
               case (estado_q)
                  LEITURA: begin
                     resp_dado_d = carga;
                     estado_d    = FIM;
                  end
                  RMW_LEITURA: begin
                     mem_val_d = mescla;
                     estado_d  = RMW_ESCRITA;
                  end
                  default: estado_d = FIM;
               endcase
            end else if (cnt_q == CNT_FIM) begin
               mem_req_d  = 1'b0;
               mem_ctl_d  = CTRL_LEITURA;
               erro_lim_d = 1'b1;
               estado_d   = FIM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FIM:     estado_d = OCIOSO;
         default: estado_d = OCIOSO;
      endcase

      resp_valido_d = (estado_d == FIM);
   end

   assign stall            = req_valido && (estado_q != FIM);
   assign resp_valido      = resp_valido_q;
   assign resp_dado        = resp_dado_q;
   assign erro_alinhamento = erro_alin_q;
   assign erro_limite      = erro_lim_q;
   assign mem.mem_req      = mem_req_q;
   assign mem.mem_endereco = mem_end_q;
   assign mem.mem_valor    = mem_val_q;
   assign mem.mem_controle = mem_ctl_q;

endmodule
